// File: rtl/mac_tile_dual.sv
// mac_tile_dual: one systolic MAC tile that runs either weight-stationary or output-stationary dataflow.
//   clk, reset     clock and synchronous active-high reset
//   mode           0 = weight-stationary, 1 = output-stationary
//   in_w / out_e   activation (or weight during a WS load) from the west, registered copy to the east
//   inst_w / inst_e instruction {flush, execute, load} from the west, registered copy to the east
//   in_n / out_s   WS: psum in and out; OS: weight in and weight passed south, or flushed result out
module mac_tile_dual #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter bit SAT     = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [BW-1:0]      in_w,
    output logic [BW-1:0]      out_e,
    input  logic [2:0]         inst_w,
    output logic [2:0]         inst_e,
    input  logic [PSUM_BW-1:0] in_n,
    output logic [PSUM_BW-1:0] out_s
);
    logic               mode_q, loaded, loaded_d;
    logic [BW-1:0]      w_q, w_d, out_e_d;
    logic [PSUM_BW-1:0] acc, acc_d, out_s_d;
    logic [2:0]         inst_e_d;
    logic               flush, exec, load;

    // Activation is unsigned, weight is signed; the product always fits in PSUM_BW,
    // so a modulo-2^PSUM_BW multiply of the extended operands is exact.
    function automatic logic [PSUM_BW-1:0] prod(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [PSUM_BW-1:0] ax, bx;
        ax = {{(PSUM_BW-BW){1'b0}}, a};
        bx = {{(PSUM_BW-BW){b[BW-1]}}, b};
        return ax * bx;
    endfunction

    // One extra bit exposes signed overflow; SAT clamps, otherwise it wraps.
    function automatic logic [PSUM_BW-1:0] add(input logic [PSUM_BW-1:0] x, input logic [PSUM_BW-1:0] y);
        logic [PSUM_BW:0] s;
        s = {x[PSUM_BW-1], x} + {y[PSUM_BW-1], y};
        if (SAT && (s[PSUM_BW] != s[PSUM_BW-1]))
            return s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
        return s[PSUM_BW-1:0];
    endfunction

    assign flush = inst_w[2];
    assign exec  = inst_w[1] & ~inst_w[2];
    assign load  = inst_w[0] & ~inst_w[1] & ~inst_w[2];

    always_comb begin
        out_e_d  = out_e;
        out_s_d  = out_s;
        inst_e_d = 3'b000;
        acc_d    = acc;
        w_d      = w_q;
        loaded_d = loaded;
        if (mode != mode_q) begin
            // A dataflow switch discards tile state and swallows this cycle's instruction.
            acc_d    = '0;
            loaded_d = 1'b0;
        end else if (flush) begin
            // OS: acc shifts down the column, so R tiles drain in R cycles, bottom first.
            inst_e_d = inst_w;
            out_s_d  = mode ? acc : in_n;
            acc_d    = mode ? in_n : acc;
        end else if (exec) begin
            inst_e_d = inst_w;
            out_e_d  = in_w;
            out_s_d  = mode ? {{(PSUM_BW-BW){in_n[BW-1]}}, in_n[BW-1:0]} : add(in_n, prod(in_w, w_q));
            acc_d    = mode ? add(acc, prod(in_w, in_n[BW-1:0])) : acc;
        end else if (load) begin
            // The first WS load cycle keeps the weight here; later ones forward it east.
            inst_e_d = {2'b00, mode | loaded};
            out_e_d  = (mode | loaded) ? in_w : out_e;
            w_d      = (mode | loaded) ? w_q : in_w;
            loaded_d = loaded | ~mode;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 1'b0;
            loaded <= 1'b0;
            w_q    <= '0;
            acc    <= '0;
            out_e  <= '0;
            out_s  <= '0;
            inst_e <= '0;
        end else begin
            mode_q <= mode;
            loaded <= loaded_d;
            w_q    <= w_d;
            acc    <= acc_d;
            out_e  <= out_e_d;
            out_s  <= out_s_d;
            inst_e <= inst_e_d;
        end
    end
endmodule
